bcd_updown_counter_n: RTL and testbench
=======================================

// Module: bcd_updown_counter_n
// PURPOSE
//   N-digit cascadable BCD (decade) up/down counter with asynchronous clear,
//   synchronous parallel load, count enable, and wrap or saturate mode.
//   Multi-digit successor of the 4-bit decade up counter; used for
//   event/timer counts that are displayed or compared in decimal.
//   TC/INV outputs let instances chain into wider counters.
// PARAMETERS
//   DIGITS  4  number of BCD digits (1..8); counter width W = 4*DIGITS
//   SAT     0  0 = wrap at terminal (99..9 -> 0 up, 0 -> 99..9 down); 1 = hold at terminal
// PORTS
//   CLK   in   1  rising-edge clock
//   CD    in   1  asynchronous clear, active-high; Q -> 0
//   LD    in   1  synchronous parallel load of D
//   EN    in   1  count enable (cascade input)
//   UP    in   1  direction: 1 = up, 0 = down; sampled each CLK
//   D     in   W  load data; digit k = D[4k+3:4k], digit 0 = least significant
//   Q     out  W  counter value, same digit layout as D
//   TC    out  1  combinational terminal count: EN & ~INV & every digit == 9 (UP=1)
//                 or every digit == 0 (UP=0); drives EN of the next stage
//   WRAP  out  1  registered; 1-cycle pulse in the cycle after Q wrapped (SAT=0 only)
//   INV   out  1  combinational: 1 when any digit of Q is in 10..15
// BEHAVIOUR
//   - Reset: CD=1 forces Q=0 and WRAP=0 immediately, independent of CLK;
//     held while CD=1. INV=0 and TC=EN&~UP, both derived from Q=0.
//   - Priority at each rising CLK edge (CD=0): LD > EN > hold.
//   - LD=1: Q <= D, WRAP <= 0. Digits 10..15 are loaded unchanged, so INV rises.
//   - EN=1, LD=0, INV=0, UP=1: digit 0 increments. Digit k increments only when
//     all lower digits are 9. Each digit that passes 9 becomes 0.
//   - EN=1, LD=0, INV=0, UP=0: digit 0 decrements. Digit k decrements only when
//     all lower digits are 0. Each digit that passes 0 becomes 9.
//   - Terminal (TC=1) with SAT=0: Q wraps to all-0 (up) or all-9 (down); WRAP <= 1.
//   - Terminal with SAT=1: Q holds; WRAP stays 0.
//   - INV=1: counting is suppressed and Q holds. Only LD or CD recovers.
//     This is the multi-digit form of the decade counter's freeze on 10..15.
//   - WRAP is 0 in every cycle with no wrap event, including LD cycles and hold cycles.
//   - Latency: Q updates 1 CLK after LD/EN sampling. TC/INV have zero latency from Q and EN.
//   - Direction change takes effect on the edge where the new UP is sampled.
//     No extra cycle, no glitch state.
//   - CD asserted mid-count or coincident with LD/EN: CD wins and Q=0.
//     First count happens on the first edge with CD=0.
//   - Arithmetic is per-digit modulo-10 with a carry/borrow chain, never binary modulo-2^W.
//     Q never leaves 0..9 per digit unless loaded that way.
// TESTING
//   1 DIGITS=2,SAT=0: CD pulse, EN=1 UP=1 for 100 clks -> Q 00..99,00; WRAP=1 one clk after 99->00; TC=1 only at 99
//   2 DIGITS=2: LD D=0x19, UP=1 EN=1 1 clk -> Q=0x20; UP=0 2 clks -> 0x19,0x18
//   3 DIGITS=3,SAT=0: LD 0x000, UP=0 EN=1 -> Q=0x999, WRAP=1; SAT=1 same stimulus -> Q stays 0x000, WRAP=0
//   4 LD D=0x1A (DIGITS=2) -> INV=1, EN=1 5 clks -> Q stays 0x1A; LD 0x05 -> INV=0, counting resumes
//   5 Assert CD between edges while Q=0x47, EN=1 -> Q=0 asynchronously; LD=1 with CD=1 -> Q stays 0
//   6 Two DIGITS=1 instances chained (TC0->EN1), count up from 08 -> 09,10,11; matches single DIGITS=2 instance

Source files
------------

// File: rtl/bcd_updown_counter_n.sv
// bcd_updown_counter_n: cascadable N-digit BCD up/down counter with async clear, load, wrap/saturate
module bcd_updown_counter_n #(
  parameter int DIGITS = 4,
  parameter bit SAT = 1'b0
) (
  input  logic                  CLK,
  input  logic                  CD,
  input  logic                  LD,
  input  logic                  EN,
  input  logic                  UP,
  input  logic [4*DIGITS-1:0]   D,
  output logic [4*DIGITS-1:0]   Q,
  output logic                  TC,
  output logic                  WRAP,
  output logic                  INV
);
  logic [DIGITS:0]     lo9, lo0;
  logic [DIGITS-1:0]   bad;
  logic [4*DIGITS-1:0] nxt;
  logic                term;
  assign lo9[0] = 1'b1;
  assign lo0[0] = 1'b1;
  // lo9[k]/lo0[k]: every digit below k is 9/0, i.e. digit k receives the carry/borrow
  for (genvar k = 0; k < DIGITS; k++) begin : g_dig
    logic [3:0] d;
    assign d          = Q[4*k+:4];
    assign bad[k]     = d > 4'd9;
    assign lo9[k+1]   = lo9[k] & (d == 4'd9);
    assign lo0[k+1]   = lo0[k] & (d == 4'd0);
    assign nxt[4*k+:4] = UP ? (lo9[k] ? ((d == 4'd9) ? 4'd0 : d + 4'd1) : d)
                            : (lo0[k] ? ((d == 4'd0) ? 4'd9 : d - 4'd1) : d);
  end
  assign INV  = |bad;
  assign term = UP ? lo9[DIGITS] : lo0[DIGITS];
  assign TC   = EN & ~INV & term;
  always_ff @(posedge CLK or posedge CD) begin
    if (CD) begin
      Q    <= '0;
      WRAP <= 1'b0;
    end else if (LD) begin
      Q    <= D;
      WRAP <= 1'b0;
    end else begin
      WRAP <= TC & ~SAT;
      if (EN & ~INV & ~(TC & SAT)) Q <= nxt;
    end
  end
endmodule

// File: tb/tb_bcd_updown_counter_n.sv
// tb_bcd_updown_counter_n: random + directed checks of the BCD counter against a decimal model
module tb_bcd_updown_counter_n;
  logic clk = 1'b0, cd = 1'b0, ld = 1'b0, en = 1'b0, up = 1'b1;
  logic [7:0]  d2 = '0;
  logic [11:0] d3 = '0;
  logic [7:0]  q2;
  logic [11:0] q3w, q3s;
  logic [3:0]  qc0, qc1;
  logic tc2, wr2, inv2, tc3w, wr3w, inv3w, tc3s, wr3s, inv3s;
  logic tc0, tc1, wc0, wc1, ic0, ic1;
  int compared = 0, mismatched = 0;
  logic [31:0] m2 = '0, m3w = '0, m3s = '0;
  logic mw2 = 1'b0, mw3w = 1'b0, mw3s = 1'b0;

  always #5 clk = ~clk;

  bcd_updown_counter_n #(.DIGITS(2), .SAT(1'b0)) u2 (.CLK(clk), .CD(cd), .LD(ld), .EN(en), .UP(up),
    .D(d2), .Q(q2), .TC(tc2), .WRAP(wr2), .INV(inv2));
  bcd_updown_counter_n #(.DIGITS(3), .SAT(1'b0)) u3w (.CLK(clk), .CD(cd), .LD(ld), .EN(en), .UP(up),
    .D(d3), .Q(q3w), .TC(tc3w), .WRAP(wr3w), .INV(inv3w));
  bcd_updown_counter_n #(.DIGITS(3), .SAT(1'b1)) u3s (.CLK(clk), .CD(cd), .LD(ld), .EN(en), .UP(up),
    .D(d3), .Q(q3s), .TC(tc3s), .WRAP(wr3s), .INV(inv3s));
  bcd_updown_counter_n #(.DIGITS(1), .SAT(1'b0)) uc0 (.CLK(clk), .CD(cd), .LD(ld), .EN(en), .UP(up),
    .D(d2[3:0]), .Q(qc0), .TC(tc0), .WRAP(wc0), .INV(ic0));
  bcd_updown_counter_n #(.DIGITS(1), .SAT(1'b0)) uc1 (.CLK(clk), .CD(cd), .LD(ld), .EN(tc0), .UP(up),
    .D(d2[7:4]), .Q(qc1), .TC(tc1), .WRAP(wc1), .INV(ic1));

  function automatic bit ok(input logic [31:0] v, input int n);
    for (int i = 0; i < n; i++) if (v[4*i+:4] > 4'd9) return 1'b0;
    return 1'b1;
  endfunction

  function automatic int val(input logic [31:0] v, input int n);
    int r = 0;
    for (int i = n - 1; i >= 0; i--) r = r * 10 + int'(v[4*i+:4]);
    return r;
  endfunction

  function automatic logic [31:0] bcd(input int x, input int n);
    logic [31:0] r = '0;
    for (int i = 0; i < n; i++) begin
      r[4*i+:4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic int top(input int n);
    int r = 1;
    for (int i = 0; i < n; i++) r = r * 10;
    return r - 1;
  endfunction

  function automatic bit term(input logic [31:0] v, input int n, input logic u);
    return ok(v, n) && (u ? val(v, n) == top(n) : val(v, n) == 0);
  endfunction

  task automatic nxt(inout logic [31:0] v, output logic w, input int n, input bit sat, input logic [31:0] d);
    int x;
    w = 1'b0;
    if (ld) v = d;
    else if (en && ok(v, n)) begin
      x = val(v, n);
      if (term(v, n, up)) begin
        if (!sat) begin
          x = up ? 0 : top(n);
          w = 1'b1;
        end
      end else x = up ? x + 1 : x - 1;
      v = bcd(x, n);
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("q2", {24'b0, q2}, m2);
    chk("tc2", {31'b0, tc2}, {31'b0, en && term(m2, 2, up)});
    chk("inv2", {31'b0, inv2}, {31'b0, !ok(m2, 2)});
    chk("wrap2", {31'b0, wr2}, {31'b0, mw2});
    chk("q3w", {20'b0, q3w}, m3w);
    chk("tc3w", {31'b0, tc3w}, {31'b0, en && term(m3w, 3, up)});
    chk("inv3w", {31'b0, inv3w}, {31'b0, !ok(m3w, 3)});
    chk("wrap3w", {31'b0, wr3w}, {31'b0, mw3w});
    chk("q3s", {20'b0, q3s}, m3s);
    chk("tc3s", {31'b0, tc3s}, {31'b0, en && term(m3s, 3, up)});
    chk("wrap3s", {31'b0, wr3s}, {31'b0, mw3s});
    if (ok(m2, 2)) chk("chain", {24'b0, qc1, qc0}, m2);
  endtask

  // one clock: apply inputs after the falling edge, check, optionally pulse CD, then advance the model
  task automatic cyc(input logic l, input logic e, input logic u, input logic [7:0] a,
                     input logic [11:0] b, input bit clr);
    logic w;
    @(negedge clk);
    ld = l; en = e; up = u; d2 = a; d3 = b; cd = 1'b0;
    #1 check_all();
    if (clr) begin
      #2 cd = 1'b1;
      m2 = '0; m3w = '0; m3s = '0; mw2 = 1'b0; mw3w = 1'b0; mw3s = 1'b0;
      #1 check_all();
    end
    @(posedge clk);
    if (!clr) begin
      nxt(m2, w, 2, 1'b0, {24'b0, d2}); mw2 = w;
      nxt(m3w, w, 3, 1'b0, {20'b0, d3}); mw3w = w;
      nxt(m3s, w, 3, 1'b1, {20'b0, d3}); mw3s = w;
    end
  endtask

  initial begin
    logic [11:0] r;
    logic dir;
    cyc(1'b0, 1'b0, 1'b1, 8'h00, 12'h000, 1'b1);
    cyc(1'b1, 1'b0, 1'b1, 8'h00, 12'h000, 1'b0);
    repeat (101) cyc(1'b0, 1'b1, 1'b1, 8'h00, 12'h000, 1'b0);
    #1 chk("t1_q01", {24'b0, q2}, 32'h01);
    cyc(1'b1, 1'b0, 1'b1, 8'h19, 12'h019, 1'b0);
    cyc(1'b0, 1'b1, 1'b1, 8'h00, 12'h000, 1'b0);
    #1 chk("t2_q20", {24'b0, q2}, 32'h20);
    cyc(1'b0, 1'b1, 1'b0, 8'h00, 12'h000, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 8'h00, 12'h000, 1'b0);
    #1 chk("t2_q18", {24'b0, q2}, 32'h18);
    cyc(1'b1, 1'b0, 1'b0, 8'h00, 12'h000, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 8'h00, 12'h000, 1'b0);
    #1 chk("t3_q999", {20'b0, q3w}, 32'h999);
    chk("t3_wrap", {31'b0, wr3w}, 32'h1);
    chk("t3_sat", {20'b0, q3s}, 32'h000);
    chk("t3_satw", {31'b0, wr3s}, 32'h0);
    cyc(1'b1, 1'b0, 1'b1, 8'h1A, 12'h01A, 1'b0);
    repeat (5) cyc(1'b0, 1'b1, 1'b1, 8'h00, 12'h000, 1'b0);
    #1 chk("t4_hold", {24'b0, q2}, 32'h1A);
    chk("t4_inv", {31'b0, inv2}, 32'h1);
    cyc(1'b1, 1'b0, 1'b1, 8'h05, 12'h005, 1'b0);
    cyc(1'b0, 1'b1, 1'b1, 8'h00, 12'h000, 1'b0);
    #1 chk("t4_resume", {24'b0, q2}, 32'h06);
    cyc(1'b1, 1'b0, 1'b1, 8'h47, 12'h047, 1'b0);
    cyc(1'b0, 1'b1, 1'b1, 8'h00, 12'h000, 1'b1);
    #1 chk("t5_clr", {24'b0, q2}, 32'h00);
    cyc(1'b1, 1'b1, 1'b1, 8'h33, 12'h333, 1'b1);
    #1 chk("t5_ldclr", {24'b0, q2}, 32'h00);
    cyc(1'b1, 1'b0, 1'b1, 8'h08, 12'h008, 1'b0);
    repeat (3) cyc(1'b0, 1'b1, 1'b1, 8'h00, 12'h000, 1'b0);
    #1 chk("t6_chain", {24'b0, qc1, qc0}, 32'h11);
    repeat (3) cyc(1'b0, 1'b1, 1'b0, 8'h00, 12'h000, 1'b0);
    #1 chk("t6_down", {24'b0, qc1, qc0}, 32'h08);
    dir = 1'b1;
    repeat (800) begin
      r = '0;
      for (int i = 0; i < 3; i++) r[4*i+:4] = 4'($urandom_range(0, 9));
      if ($urandom_range(0, 7) == 0) r = 12'($urandom);
      if ($urandom_range(0, 9) == 0) dir = ~dir;
      cyc($urandom_range(0, 15) == 0, $urandom_range(0, 3) != 0, dir, r[7:0], r,
          $urandom_range(0, 60) == 0);
    end
    @(negedge clk);
    ld = 1'b0; en = 1'b0; cd = 1'b0;
    #1 check_all();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
